packet_mux: RTL

//  Downstream consumer of the round-robin arbiter. Drives the arbiter's request vector from NUM_PORTS

---
 rtl/packet_mux.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/packet_mux.sv
// packet_mux: forwards one arbiter-granted input packet stream at a time to a
// single registered output stream. A port stays locked from the first accepted
// grant until its last beat, then the request vector drops for one cycle so the
// arbiter can rotate.
// Optional build macro: PACKET_MUX_STATS_EN adds per-port packet counters
// (pkt_count) and a sticky bad-grant flag (grant_err).

// Per-port slice: handshake gating, data masking and (optionally) the packet counter.
module packet_mux_lane #(
    parameter int DATA_WIDTH = 32
) (
`ifdef PACKET_MUX_STATS_EN
    input  logic                  clk,
    input  logic                  rst,
    output logic [15:0]           o_count,
`endif
    input  logic                  i_lock,
    input  logic                  i_fwd,
    input  logic                  i_out_free,
    input  logic                  i_valid,
    input  logic                  i_last,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_fire,
    output logic                  o_last,
    output logic [DATA_WIDTH-1:0] o_data
);
    // Only the locked lane may ever be ready; its data/last are masked so the
    // top-level mux is a plain OR and unlocked s_data never reaches a register.
    assign o_ready = i_fwd & i_lock & i_out_free;
    assign o_fire  = o_ready & i_valid;
    assign o_last  = i_lock & i_last;
    assign o_data  = i_lock ? i_data : '0;

`ifdef PACKET_MUX_STATS_EN
    logic [15:0] r_count;

    // Count completed packets; the 16-bit counter wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (o_fire && i_last)
            r_count <= r_count + 16'd1;
    end

    assign o_count = r_count;
`endif
endmodule

module packet_mux #(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            s_valid,
    input  logic [NUM_PORTS-1:0]            s_last,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [NUM_PORTS-1:0]            request,
    input  logic [NUM_PORTS-1:0]            grant,
    input  logic                            active,
    output logic                            m_valid,
    output logic                            m_last,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [IDX_WIDTH-1:0]            m_port,
`ifdef PACKET_MUX_STATS_EN
    output logic [NUM_PORTS*16-1:0]         pkt_count,
    output logic                            grant_err,
`endif
    input  logic                            m_ready
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FWD     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                               r_state;
    logic [NUM_PORTS-1:0]                 r_lock;
    logic [IDX_WIDTH-1:0]                 r_idx;
    logic                                 r_m_valid;
    logic                                 r_m_last;
    logic [DATA_WIDTH-1:0]                r_m_data;
    logic [IDX_WIDTH-1:0]                 r_m_port;

    logic                                 w_fwd;
    logic                                 w_out_free;
    logic                                 w_grant_onehot;
    logic                                 w_grant_valid;
    logic                                 w_take_grant;
    logic [IDX_WIDTH-1:0]                 w_grant_idx;
    logic [NUM_PORTS-1:0]                 w_fire;
    logic [NUM_PORTS-1:0]                 w_lane_last;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_lane_data;
    logic                                 w_accept;
    logic                                 w_beat_last;
    logic [DATA_WIDTH-1:0]                w_beat_data;

    assign w_fwd      = (r_state == FWD);
    // The single output slot can take a beat if empty or draining this cycle.
    assign w_out_free = ~r_m_valid | m_ready;

    // A grant is only honoured if it is one-hot and names a port that is
    // actually presenting a beat; anything else is left for the arbiter to fix.
    assign w_grant_onehot = (grant != '0) && ((grant & (grant - NUM_PORTS'(1))) == '0);
    assign w_grant_valid  = ((grant & ~s_valid) == '0);
    assign w_take_grant   = (r_state == IDLE) && active && w_grant_onehot && w_grant_valid;

    // Encode the granted port index once, at lock time.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (grant[i]) w_grant_idx = IDX_WIDTH'(i);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_lane
            packet_mux_lane #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
`ifdef PACKET_MUX_STATS_EN
                .clk        (clk),
                .rst        (rst),
                .o_count    (pkt_count[g*16 +: 16]),
`endif
                .i_lock     (r_lock[g]),
                .i_fwd      (w_fwd),
                .i_out_free (w_out_free),
                .i_valid    (s_valid[g]),
                .i_last     (s_last[g]),
                .i_data     (s_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_ready    (s_ready[g]),
                .o_fire     (w_fire[g]),
                .o_last     (w_lane_last[g]),
                .o_data     (w_lane_data[g])
            );
        end
    endgenerate

    // OR-reduce the masked lanes; at most one is locked.
    always_comb begin
        w_beat_data = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            w_beat_data = w_beat_data | w_lane_data[i];
    end

    assign w_accept    = |w_fire;
    assign w_beat_last = |w_lane_last;

    // Request: raw valids while idle, the lock while forwarding (held through
    // source gaps), and nothing during RELEASE or reset so the arbiter rotates.
    always_comb begin
        request = '0;
        if (!rst) begin
            case (r_state)
                IDLE:    request = s_valid;
                FWD:     request = r_lock;
                default: request = '0;
            endcase
        end
    end

    // Port-lock FSM: latch a clean grant, forward until the last beat, release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_lock  <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take_grant) begin
                        r_lock  <= grant;
                        r_idx   <= w_grant_idx;
                        r_state <= FWD;
                    end
                end
                FWD: begin
                    if (w_accept && w_beat_last)
                        r_state <= RELEASE;
                end
                RELEASE: begin
                    r_lock  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_lock  <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output slot: load on accept (even while draining), clear on drain only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_port  <= '0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_beat_last;
            r_m_data  <= w_beat_data;
            r_m_port  <= r_idx;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_data  = r_m_data;
    assign m_port  = r_m_port;

`ifdef PACKET_MUX_STATS_EN
    logic r_grant_err;
    logic w_grant_bad;

    // Multi-hot, or naming a port that is not presenting a beat.
    assign w_grant_bad = ((grant != '0) && !w_grant_onehot) || !w_grant_valid;

    // Sticky bad-grant flag, only meaningful while waiting for a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_grant_err <= 1'b0;
        else if ((r_state == IDLE) && active && w_grant_bad)
            r_grant_err <= 1'b1;
    end

    assign grant_err = r_grant_err;
`else
    // Statistics disabled: no counters and no grant-error flag are built.
`endif
endmodule
